// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of one single-port RAM.
// Clears the RAM after reset, then serves one round-robin access per cycle.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    last_grant;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    grant0;
  logic                    grant1;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // On contention the requester that lost last time wins; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == RUN) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = init_cnt;
    mem_wdata = '0;
    if (state == INIT) begin
      mem_we = 1'b1;
    end else if (grant0) begin
      mem_we    = req0_write;
      mem_addr  = req0_addr;
      mem_wdata = req0_data;
    end else if (grant1) begin
      mem_we    = req1_write;
      mem_addr  = req1_addr;
      mem_wdata = req1_data;
    end
  end

  // Storage has no reset; only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_cnt   <= '0;
      last_grant <= 1'b1;
      init_done  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= grant0 && !req0_write;
      rsp1_valid <= grant1 && !req1_write;
      if (grant0 && !req0_write) begin
        rsp0_data <= mem[mem_addr];
      end
      if (grant1 && !req1_write) begin
        rsp1_data <= mem[mem_addr];
      end
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (grant0) begin
            last_grant <= 1'b0;
          end else if (grant1) begin
            last_grant <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter against a queue-free
// behavioural model: memory array, last winner and pending response per port.
module tb_ram_port_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          init_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  int            last_winner;
  logic          exp_rsp_valid [2];
  logic [DW-1:0] exp_rsp_data [2];

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Called just after a rising edge: drives one cycle, checks, advances to the next edge.
  task automatic applyStimulus(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               output int winner);
    logic          win_write;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_data = d1;
    #1;
    winner = -1;
    if (v0 && v1)  winner = 1 - last_winner;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    checkOutput("init_done", init_done, 1);
    checkOutput("ready0", req0_ready, winner == 0);
    checkOutput("ready1", req1_ready, winner == 1);
    checkOutput("rsp0_valid", rsp0_valid, exp_rsp_valid[0]);
    checkOutput("rsp1_valid", rsp1_valid, exp_rsp_valid[1]);
    checkOutput("rsp0_data", rsp0_data, exp_rsp_data[0]);
    checkOutput("rsp1_data", rsp1_data, exp_rsp_data[1]);
    exp_rsp_valid[0] = 1'b0;
    exp_rsp_valid[1] = 1'b0;
    if (winner >= 0) begin
      last_winner = winner;
      win_write = (winner == 0) ? w0 : w1;
      win_addr  = (winner == 0) ? a0 : a1;
      win_data  = (winner == 0) ? d0 : d1;
      if (win_write) begin
        model_mem[win_addr] = win_data;
      end else begin
        exp_rsp_valid[winner] = 1'b1;
        exp_rsp_data[winner]  = model_mem[win_addr];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", rsp1_valid, 0);
    checkOutput("rst_rsp0_data", rsp0_data, 0);
    checkOutput("rst_rsp1_data", rsp1_data, 0);
    checkOutput("rst_init_done", init_done, 0);
    last_winner = 1;
    for (int r = 0; r < 2; r++) begin
      exp_rsp_valid[r] = 1'b0;
      exp_rsp_data[r]  = '0;
    end
  endtask

  // Releases reset and counts cycles to init_done; abort_at > 0 re-asserts reset at that cycle.
  task automatic runInit(input int abort_at);
    int cycles;
    cycles = 0;
    rst_n  = 1'b1;
    while (cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (init_done === 1'b1) break;
      checkOutput("init_ready0", req0_ready, 0);
      checkOutput("init_ready1", req1_ready, 0);
      if (abort_at > 0 && cycles == abort_at) begin
        assertReset();
        return;
      end
    end
    checkOutput("init_len", cycles, DEPTH);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic randomTraffic(input int n);
    logic          pv [2];
    logic          pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    int            w;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; pw[r] = 1'b0; pa[r] = '0; pd[r] = '0;
    end
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 9) < 7) begin
          pv[r] = 1'b1;
          pw[r] = ($urandom_range(0, 2) == 0);
          pa[r] = AW'($urandom_range(0, 7));
          pd[r] = DW'($urandom);
        end
      end
      applyStimulus(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], w);
      if (w >= 0) pv[w] = 1'b0;
    end
  endtask

  initial begin
    int w;
    #12;
    assertReset();

    // Requests held throughout INIT must wait; req0 wins the first contention.
    req0_valid = 1'b1; req0_addr = 6'd3;
    req1_valid = 1'b1; req1_addr = 6'd4;
    runInit(0);
    applyStimulus(1, 0, 6'd3, 8'h00, 1, 0, 6'd4, 8'h00, w);
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, 6'd4, 8'h00, w);

    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 6'd1, 8'h00, 1, 0, 6'd2, 8'h00, w);

    applyStimulus(1, 1, 6'd5, 8'hA5, 0, 0, 6'd0, 8'h00, w);
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, 6'd5, 8'h00, w);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, w);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, AW'(i + 5), 8'h00, w);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, w);

    randomTraffic(400);

    // Reset with a read response in flight, then abort INIT at cycle 30.
    applyStimulus(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, w);
    assertReset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    runInit(30);
    runInit(0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, AW'(i), 8'h00, 1, 0, AW'(i + 32), 8'h00, w);
    randomTraffic(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  requester N presents an access.
REQ-006 SHALL have ports req0_write, req1_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr, req1_addr  input  ADDR_WIDTH  access address.
REQ-008 SHALL have ports req0_data, req1_data  input  DATA_WIDTH  write data; ignored on reads.
REQ-009 SHALL have ports req0_ready, req1_ready  output  1  access accepted this cycle (combinational).
REQ-010 SHALL have ports rsp0_valid, rsp1_valid  output  1  registered read data valid, one cycle.
REQ-011 SHALL have ports rsp0_data, rsp1_data  output  DATA_WIDTH  read data.
REQ-012 SHALL have port init_done  output  1  memory clear complete, arbiter serving.

Function
REQ-013 SHALL contain one single-port storage array of 2**ADDR_WIDTH x DATA_WIDTH, at most one access per cycle.
REQ-014 SHALL implement a two-state FSM: INIT, RUN.
REQ-015 In INIT, SHALL write 0 to address init_cnt each cycle, init_cnt counting 0 to 2**ADDR_WIDTH-1.
REQ-016 SHALL move INIT->RUN on the edge that writes address 2**ADDR_WIDTH-1; init_done = 1 from the following cycle; INIT lasts exactly 2**ADDR_WIDTH cycles.
REQ-017 In INIT, SHALL hold req0_ready = req1_ready = 0 and ignore all requests.
REQ-018 RUN SHALL have no exit except reset.
REQ-019 In RUN, handshake: access N accepted on an edge where reqN_valid = 1 and reqN_ready = 1; requester holds valid/write/addr/data stable until accepted.
REQ-020 SHALL assert at most one reqN_ready per cycle; reqN_ready never asserted without reqN_valid.
REQ-021 Only one valid: SHALL grant it, regardless of priority.
REQ-022 Both valid: SHALL grant the requester not granted most recently (round-robin via a 1-bit last_grant register, updated on every acceptance).
REQ-023 last_grant reset value 1, so requester 0 wins the first contention.
REQ-024 Accepted write: SHALL update the array on the acceptance edge; no response generated.
REQ-025 Accepted read: SHALL set rspN_valid = 1 for exactly the next cycle with rspN_data = array[addr] as of the acceptance edge (read latency 1).
REQ-026 Read of an address written on an earlier edge SHALL return the new data; back-to-back write then read to same address from different requesters returns the written value.
REQ-027 rspN_valid SHALL NOT be back-pressured; rspN_data holds its last value when rspN_valid = 0.
REQ-028 Sustained throughput SHALL be one access per cycle; both requesters continuously valid alternate 0,1,0,1.

Reset
REQ-029 rst_n low SHALL immediately, without clk: state = INIT, init_cnt = 0, last_grant = 1, init_done = 0, req*_ready = 0, rsp*_valid = 0, rsp*_data = 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight response and restart the full clear sequence after rst_n deasserts.
REQ-031 Array contents SHALL NOT be cleared asynchronously; only by the INIT sequence.

Verification
REQ-032 Reset release, defaults -> init_done rises after exactly 64 cycles; any read in RUN returns 0x00.
REQ-033 req0 write addr 5 data 0xA5, then req1 read addr 5 -> req1 accepted next cycle, rsp1_valid one cycle later, rsp1_data = 0xA5, rsp0_valid stays 0.
REQ-034 Both valid continuously with reads of addr 1 (req0) and addr 2 (req1) -> grants alternate 0,1,0,1 starting with 0; exactly one ready per cycle.
REQ-035 Only req1 valid for 4 cycles -> accepted every cycle, no idle gaps.
REQ-036 rst_n pulsed low at INIT cycle 30 -> outputs to reset values at once; init_done rises 64 cycles after release.
REQ-037 Requests asserted during INIT -> ready held 0 until init_done; first grant on the first RUN cycle.
